// File: rtl/radix4_mul_arbiter_pkg.sv
// rtl/radix4_mul_arbiter_pkg.sv - shared types and widths for the radix-4 multiplier arbiter
package radix4_arb_pkg;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/radix4_mul_arbiter_if.sv
// rtl/radix4_mul_arbiter_if.sv - requester-side request/ack/response bundle
interface radix4_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import radix4_arb_pkg::*;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*OPERAND_W-1:0] req_x;
    logic [NUM_REQ*OPERAND_W-1:0] req_y;
    logic [NUM_REQ-1:0]           req_ack;
    logic [NUM_REQ-1:0]           resp_valid;
    logic [RESULT_W-1:0]          resp_result;
    logic                         resp_err;

    modport master (
        output req_valid, req_x, req_y,
        input  req_ack, resp_valid, resp_result, resp_err
    );

    modport slave (
        input  req_valid, req_x, req_y,
        output req_ack, resp_valid, resp_result, resp_err
    );

endinterface

// File: rtl/radix4_mul_arbiter_rr_picker.sv
// rtl/radix4_mul_arbiter_rr_picker.sv - combinational round-robin picker, search starts after last_grant
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int               idx;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        sel       = '0;
        // k = NUM_REQ wraps back to last_grant itself, so it has lowest priority
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            sel = IDX_W'(idx);
            if (!any && req_valid[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/radix4_mul_arbiter.sv
// rtl/radix4_mul_arbiter.sv - shares one signed 8x8 multiplier among NUM_REQ requesters
// Optional watchdog: define RADIX4_ARB_TIMEOUT_EN.
module radix4_mul_arbiter
    import radix4_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    radix4_mul_arbiter_if.slave  req_if,
    output logic                 busy,
    output logic                 mul_start,
    output logic [OPERAND_W-1:0] mul_x,
    output logic [OPERAND_W-1:0] mul_y,
    input  logic [RESULT_W-1:0]  mul_result,
    input  logic                 mul_ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     cur;
    logic                 any;
    logic                 mul_ready_q;
    logic                 ready_edge;
    logic                 to_hit;
    logic [OPERAND_W-1:0] x_sel, y_sel;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_valid  (req_if.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (any)
    );

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                x_sel = req_if.req_x[i*OPERAND_W +: OPERAND_W];
                y_sel = req_if.req_y[i*OPERAND_W +: OPERAND_W];
            end
        end
    end

    // A ready level left over from the previous operation must not complete this one
    assign ready_edge = mul_ready & ~mul_ready_q;

`ifdef RADIX4_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            resp_err_q;

    assign to_hit = (state == ST_RUN) && !ready_edge && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                to_cnt <= '0;
            end else if (state == ST_RUN) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (state == ST_RUN && (ready_edge || to_hit)) begin
                resp_err_q <= to_hit;
            end
        end
    end

    assign req_if.resp_err = resp_err_q;
`else
    logic unused_timeout;

    assign unused_timeout  = (TIMEOUT > 0);
    assign to_hit          = 1'b0;
    assign req_if.resp_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= ST_IDLE;
            last_grant         <= IDX_W'(NUM_REQ - 1);
            cur                <= '0;
            mul_x              <= '0;
            mul_y              <= '0;
            req_if.resp_result <= '0;
            mul_ready_q        <= 1'b0;
        end else begin
            state       <= state_nxt;
            mul_ready_q <= mul_ready;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        cur   <= grant_idx;
                        mul_x <= x_sel;
                        mul_y <= y_sel;
                    end
                end
                ST_RUN: begin
                    if (ready_edge) begin
                        req_if.resp_result <= mul_result;
                    end else if (to_hit) begin
                        req_if.resp_result <= '0;
                    end
                end
                ST_RESP: last_grant <= cur;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any) state_nxt = ST_RUN;
            ST_RUN:  if (ready_edge || to_hit) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The ack is combinational from req_valid, so it is masked while reset is held
    assign req_if.req_ack = (state == ST_IDLE && reset) ? grant : '0;

    always_comb begin
        req_if.resp_valid = '0;
        if (state == ST_RESP) begin
            req_if.resp_valid[cur] = 1'b1;
        end
    end

    assign mul_start = (state == ST_RUN);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_radix4_mul_arbiter.sv
// tb/tb_radix4_mul_arbiter.sv - directed self-checking bench for radix4_mul_arbiter
module tb_radix4_mul_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic        mul_start;
    logic [7:0]  mul_x, mul_y;
    logic [15:0] mul_result;
    logic        mul_ready;
    bit          auto_mul;
    int          lat_cnt = 0;
    int          tests   = 0;
    int          fails   = 0;
    logic signed [15:0] prod;

    always #5 clock = ~clock;

    radix4_mul_arbiter_if #(.NUM_REQ(4)) rif ();

    radix4_mul_arbiter #(
        .NUM_REQ (4),
        .TIMEOUT (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_if     (rif),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_result (mul_result),
        .mul_ready  (mul_ready)
    );

    // External multiplier: ready rises on the 4th cycle of start, drops once start falls
    always @(posedge clock) begin
        #1;
        if (auto_mul) begin
            if (mul_start) begin
                lat_cnt = lat_cnt + 1;
                if (lat_cnt == 4) begin
                    prod       = $signed(mul_x) * $signed(mul_y);
                    mul_result = prod;
                    mul_ready  = 1'b1;
                end
            end else begin
                lat_cnt   = 0;
                mul_ready = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int x, input int y);
        rif.req_x[i*8 +: 8] = x[7:0];
        rif.req_y[i*8 +: 8] = y[7:0];
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock); #2;
        reset = 1'b1;
    endtask

    // Called at +2 after an edge with requests already driven; returns in the RESP cycle
    task automatic run_op(input int g, input int exp, input bit rel);
        int n;
        n = 0;
        #1;
        while (rif.req_ack == '0 && n < 20) begin
            @(posedge clock); #3;
            n++;
        end
        chk($sformatf("ack_g%0d", g), 32'(rif.req_ack), 32'(1 << g));
        @(posedge clock); #2;
        if (rel) rif.req_valid[g] = 1'b0;
        #1;
        chk($sformatf("start_g%0d", g), 32'(mul_start), 32'(1));
        n = 0;
        while (rif.resp_valid == '0 && n < 20) begin
            @(posedge clock); #3;
            n++;
        end
        chk($sformatf("resp_valid_g%0d", g), 32'(rif.resp_valid), 32'(1 << g));
        chk($sformatf("resp_result_g%0d", g), 32'(rif.resp_result), 32'(exp[15:0]));
        chk($sformatf("resp_err_g%0d", g), 32'(rif.resp_err), 32'(0));
    endtask

    initial begin
        rif.req_valid = '0;
        rif.req_x     = '0;
        rif.req_y     = '0;
        mul_ready     = 1'b0;
        mul_result    = '0;
        auto_mul      = 1'b1;

        #3;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_mul_start", 32'(mul_start), 32'(0));
        chk("rst_mul_x", 32'(mul_x), 32'(0));
        chk("rst_mul_y", 32'(mul_y), 32'(0));
        chk("rst_resp_result", 32'(rif.resp_result), 32'(0));
        chk("rst_resp_err", 32'(rif.resp_err), 32'(0));
        chk("rst_req_ack", 32'(rif.req_ack), 32'(0));
        chk("rst_resp_valid", 32'(rif.resp_valid), 32'(0));
        #7;
        reset = 1'b1;

        // single requester
        @(posedge clock); #2;
        set_op(0, 19, -40);
        rif.req_valid = 4'b0001;
        run_op(0, -760, 1'b1);

        // all four at once, after a fresh reset so the search starts at 0
        do_reset();
        set_op(0, 3, 4);
        set_op(1, -5, 6);
        set_op(2, 127, 127);
        set_op(3, -128, -128);
        rif.req_valid = 4'b1111;
        run_op(0, 12, 1'b1);
        run_op(1, -30, 1'b1);
        run_op(2, 16129, 1'b1);
        run_op(3, 16384, 1'b1);

        // fairness: 0 and 2 held continuously
        @(posedge clock); #2;
        set_op(0, 2, 2);
        set_op(2, -3, 3);
        rif.req_valid = 4'b0101;
        run_op(0, 4, 1'b0);
        run_op(2, -9, 1'b0);
        run_op(0, 4, 1'b0);
        run_op(2, -9, 1'b0);
        rif.req_valid = '0;

        // reset mid-RUN
        @(posedge clock); #2;
        set_op(0, 5, 5);
        rif.req_valid = 4'b0001;
        #1;
        chk("mid_ack", 32'(rif.req_ack), 32'(1));
        @(posedge clock); #2;
        chk("mid_start_before", 32'(mul_start), 32'(1));
        rif.req_valid = 4'b0100;
        reset = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_mul_start", 32'(mul_start), 32'(0));
        chk("mid_mul_x", 32'(mul_x), 32'(0));
        chk("mid_mul_y", 32'(mul_y), 32'(0));
        chk("mid_resp_result", 32'(rif.resp_result), 32'(0));
        chk("mid_resp_err", 32'(rif.resp_err), 32'(0));
        chk("mid_req_ack", 32'(rif.req_ack), 32'(0));
        chk("mid_resp_valid", 32'(rif.resp_valid), 32'(0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #3;
            chk("mid_hold_resp_valid", 32'(rif.resp_valid), 32'(0));
            chk("mid_hold_req_ack", 32'(rif.req_ack), 32'(0));
        end
        @(posedge clock); #2;
        reset = 1'b1;
        set_op(1, -7, 9);
        rif.req_valid = 4'b0010;
        run_op(1, -63, 1'b1);

        // stale ready: bench plays the multiplier by hand
        auto_mul = 1'b0;
        @(posedge clock); #2;
        set_op(0, 2, 3);
        rif.req_valid = 4'b0001;
        #1;
        chk("stale_a_ack", 32'(rif.req_ack), 32'(1));
        @(posedge clock); #2;
        rif.req_valid = '0;
        #1;
        chk("stale_a_start", 32'(mul_start), 32'(1));
        @(posedge clock); #2;
        mul_ready  = 1'b1;
        mul_result = 16'd6;
        @(posedge clock); #3;
        chk("stale_a_resp_valid", 32'(rif.resp_valid), 32'(1));
        chk("stale_a_result", 32'(rif.resp_result), 32'(6));
        @(posedge clock); #2;
        set_op(1, 10, -10);
        mul_result    = 16'hFF9C;
        rif.req_valid = 4'b0010;
        #1;
        chk("stale_b_ack", 32'(rif.req_ack), 32'(2));
        @(posedge clock); #2;
        rif.req_valid = '0;
        #1;
        chk("stale_b_start", 32'(mul_start), 32'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #3;
            chk("stale_b_no_resp", 32'(rif.resp_valid), 32'(0));
            chk("stale_b_busy", 32'(busy), 32'(1));
        end
        @(posedge clock); #2;
        mul_ready = 1'b0;
        #1;
        chk("stale_b_no_resp_low", 32'(rif.resp_valid), 32'(0));
        @(posedge clock); #2;
        mul_ready = 1'b1;
        #1;
        chk("stale_b_no_resp_rise", 32'(rif.resp_valid), 32'(0));
        @(posedge clock); #3;
        chk("stale_b_resp_valid", 32'(rif.resp_valid), 32'(2));
        chk("stale_b_result", 32'(rif.resp_result), 32'(16'hFF9C));
        @(posedge clock); #2;
        mul_ready = 1'b0;

`ifdef RADIX4_ARB_TIMEOUT_EN
        @(posedge clock); #2;
        set_op(2, 1, 1);
        rif.req_valid = 4'b0100;
        #1;
        chk("to_ack", 32'(rif.req_ack), 32'(4));
        @(posedge clock); #2;
        rif.req_valid = '0;
        #1;
        chk("to_start", 32'(mul_start), 32'(1));
        for (int i = 0; i < 7; i++) begin
            @(posedge clock); #3;
            chk("to_no_resp", 32'(rif.resp_valid), 32'(0));
        end
        @(posedge clock); #3;
        chk("to_resp_valid", 32'(rif.resp_valid), 32'(4));
        chk("to_resp_err", 32'(rif.resp_err), 32'(1));
        chk("to_resp_result", 32'(rif.resp_result), 32'(0));
`endif

        @(posedge clock); #3;
        chk("final_idle", 32'(busy), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/radix4_mul_arbiter.md
# radix4_mul_arbiter

Round-robin scheduler that shares one `radix_4_lut` signed 8x8 multiplier among `NUM_REQ` requesters. It latches one requester's operands, sequences the multiplier's `start`/`ready` handshake, and returns the 16-bit signed product to that requester only. It sits between the requesters and the multiplier instance; the multiplier is instantiated outside the block.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: watchdog limit in cycles; used only with `RADIX4_ARB_TIMEOUT_EN`.

- `clock`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester request, level, held until acked.
- `req_x`  in  NUM_REQ*8: packed signed operands; slice i = bits [8i+7:8i].
- `req_y`  in  NUM_REQ*8: packed signed operands, same slicing.
- `req_ack`  out  NUM_REQ: one-hot, 1-cycle pulse; the request is accepted.
- `resp_valid`  out  NUM_REQ: one-hot, 1-cycle pulse; `resp_result` is valid.
- `resp_result`  out  16: signed product; holds its last value.
- `resp_err`  out  1: qualifies `resp_valid`; 1 means the operation timed out. Constant 0 without the macro.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `mul_start`  out  1: to the multiplier `start` input.
- `mul_x`, `mul_y`  out  8: signed operands to the multiplier.
- `mul_result`  in  16: multiplier result.
- `mul_ready`  in  1: multiplier `ready`; only its rising edge is significant.

## Operation
- **States:** IDLE, RUN, RESP.
- **IDLE**
  - If any `req_valid` is set, the round-robin picker selects grant g: the first set bit at or after `last_grant+1`, modulo `NUM_REQ`.
  - In the same cycle: pulse `req_ack[g]`, latch `req_x[g]`/`req_y[g]` into `mul_x`/`mul_y`, store g, go to RUN.
- **RUN**
  - `mul_start` is 1 for the entire state.
  - On a `mul_ready` rising edge (`mul_ready & ~mul_ready_q`): capture `mul_result` into `resp_result`, go to RESP.
- **RESP**
  - `resp_valid[g]` is 1 for exactly one cycle; `mul_start` is 0.
  - Update `last_grant` to g; return to IDLE.
- **Operand stability:** `mul_x`/`mul_y` are stable from IDLE exit until RESP exit. Requesters may change operands after their ack.
- **Requests not granted:** they wait; no starvation. Any requester waits at most `NUM_REQ-1` operations.
- **Request dropped before ack:** it is simply not granted. After ack, the response is always delivered.
- **`mul_ready` level:** a `mul_ready` already high on entry to RUN without a new rising edge does not complete the operation.
- **Arithmetic:** no arithmetic is performed in the block; `resp_result` is a pass-through of the 16-bit signed product. The full range -128*-128 = 16384 is representable.
- **Reset (asserted at any time, including mid-RUN):**
  - State goes to IDLE, `last_grant` to `NUM_REQ-1` (first grant goes to requester 0).
  - All outputs return to 0: `req_ack`, `resp_valid`, `resp_result`, `resp_err`, `busy`, `mul_start`, `mul_x`, `mul_y`.
  - An in-flight operation is discarded with no response.

## Timing
- **Ack to start:** `req_ack` in cycle N; `mul_start` rises in cycle N+1.
- **Ready to response:** a `mul_ready` rising edge sampled at edge M puts `resp_valid` high in cycle M+1.
- **Turnaround:** minimum 2 cycles between the end of one RUN and the next `mul_start`, giving the multiplier a guaranteed low `start` cycle.
- **Throughput:** one operation per (multiplier latency + 3) cycles.
- `mul_ready_q` resets to 0.

## Configuration
- **`RADIX4_ARB_TIMEOUT_EN` defined:**
  - A counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches `TIMEOUT` without a `mul_ready` edge, go to RESP with `resp_err`=1 and `resp_result`=0.
- **Not defined:** no counter is present, `resp_err` is tied to 0, and RUN waits indefinitely.

## Structure
- **Package `radix4_arb_pkg`:** state enum (IDLE/RUN/RESP), `OPERAND_W`=8, `RESULT_W`=16.
- **Sub-module `rr_picker`:** combinational round-robin priority picker.
  - Inputs: `req_valid`, `last_grant`.
  - Outputs: one-hot `grant`, its index, and `any`.

## Test plan
- **Single requester:** reset low 10 ns; req0 x=19, y=-40; model multiplier with 4-cycle latency.
  - Expect: `req_ack[0]`, `mul_start` one cycle later, `resp_valid[0]` with `resp_result`=-760.
- **All four requesters at once:** operands (3,4), (-5,6), (127,127), (-128,-128).
  - Expect: grant order 0,1,2,3; results 12, -30, 16129, 16384 on the matching `resp_valid` bits.
- **Fairness:** req0 and req2 held high continuously.
  - Expect: grants alternate 0,2,0,2; each requester gets at least one grant per 2 operations.
- **Reset mid-RUN:** assert reset while `mul_start`=1.
  - Expect: all outputs 0 immediately and no `resp_valid`.
  - After release, a new req1 is served normally.
- **Stale ready:** `mul_ready` held high from the previous operation into the next RUN.
  - Expect: completion only on the next rising edge.
- **Timeout (with `RADIX4_ARB_TIMEOUT_EN`, `TIMEOUT`=8):** `mul_ready` held low.
  - Expect: `resp_valid` 8 cycles after `mul_start` rises, with `resp_err`=1 and `resp_result`=0.
